// File: rtl/clz_normalizer_if.sv
// Handshake and result bundle between the EX-stage sequencer and the
// leading-zero normalizer.
interface clz_normalizer_if;
  logic        start_ex;
  logic [31:0] operand_ex;
  logic        flush_ex;
  logic        busy;
  logic        done;
  logic [31:0] result_ex;
  logic [5:0]  lz_cnt;
  logic        zero;
  logic [1:0]  state_dbg;

  // valid/ready: start_ex is a request taken only when busy=0 or done=1 and
  // flush_ex=0; done is a single-cycle valid for result_ex/lz_cnt/zero and
  // needs no acknowledge.
  modport master (
    output start_ex, operand_ex, flush_ex,
    input  busy, done, result_ex, lz_cnt, zero, state_dbg
  );

  modport slave (
    input  start_ex, operand_ex, flush_ex,
    output busy, done, result_ex, lz_cnt, zero, state_dbg
  );
endinterface

// File: rtl/clz_normalizer.sv
// Multi-cycle leading-zero counter / left-normalizer: a five-step binary
// search (16, 8, 4, 2, 1) finds the shift that brings the top 1 to bit 31.
module clz_normalizer (
  input  logic              clk,
  input  logic              rst,
  clz_normalizer_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        zero_q, zero_d;

  logic [5:0]  step_w;
  logic [31:0] top_mask;

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    zero_d   = zero_q;
    step_w   = 6'd1 << step_q;
    top_mask = ~(32'hFFFF_FFFF >> step_w);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_ex && !bus.flush_ex) begin
          val_d   = bus.operand_ex;
          cnt_d   = 6'd0;
          zero_d  = (bus.operand_ex == 32'd0);
          step_d  = 3'd4;
          state_d = S_SEARCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        // Shift only when the top s bits are all zero; cnt tops out at 31.
        if ((val_q & top_mask) == 32'd0) begin
          val_d = val_q << step_w;
          cnt_d = cnt_q + step_w;
        end
        if (step_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush_ex) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      val_q   <= 32'd0;
      cnt_q   <= 6'd0;
      step_q  <= 3'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      zero_q  <= zero_d;
    end
  end

  // A zero operand searches normally; the 32 count comes only from here.
  assign bus.result_ex = zero_q ? 32'd0 : val_q;
  assign bus.lz_cnt    = zero_q ? 6'd32 : cnt_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state_q == S_SEARCH) || (state_q == S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Self-checking bench for clz_normalizer: directed handshake/flush/reset
// scenarios plus randomized operands against a bit-scan reference model.
module tb_clz_normalizer;

  logic clk;
  logic rst;
  clz_normalizer_if bus ();

  clz_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // expected entry = {zero, lz[5:0], result[31:0]}
  logic [38:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: scan from the MSB for the first 1, then shift by that count.
  function automatic logic [38:0] model(input logic [31:0] v);
    int n;
    logic [31:0] r;
    if (v == 32'd0) return {1'b1, 6'd32, 32'd0};
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    r = v << n;
    return {1'b0, 6'(n), r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] op);
    bus.start_ex   = 1'b1;
    bus.operand_ex = op;
    exp_q.push_back(model(op));
    tick();
    bus.start_ex   = 1'b0;
  endtask

  // Assumes start_op was just issued (now in cycle 1); returns in the done cycle.
  task automatic wait_done(input int budget, output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat <= budget) begin
      tick();
      lat++;
    end
    if (bus.done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_timed(input logic [31:0] op);
    start_op(op);
    for (int c = 1; c < 6; c++) begin
      check("busy_search", 32'(bus.busy), 32'd1);
      check("done_early", 32'(bus.done), 32'd0);
      tick();
    end
    check("done_c6", 32'(bus.done), 32'd1);
    tick();
    check("busy_c7", 32'(bus.busy), 32'd0);
    check("done_c7", 32'(bus.done), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        check("result_ex", bus.result_ex, e[31:0]);
        check("lz_cnt", 32'(bus.lz_cnt), 32'(e[37:32]));
        check("zero", 32'(bus.zero), 32'(e[38]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [31:0] op;

    rst            = 1'b1;
    bus.start_ex   = 1'b0;
    bus.operand_ex = 32'd0;
    bus.flush_ex   = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result_ex, 32'd0);
    check("rst_lz", 32'(bus.lz_cnt), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'd0);
    rst = 1'b0;
    tick();

    // Basic, normalized, mixed and zero operands with exact latency.
    run_timed(32'h0000_0001);
    run_timed(32'h8000_0000);
    run_timed(32'h0001_2345);
    run_timed(32'h0000_0000);

    // Start held for four cycles: only the first operand counts.
    start_op(32'h0000_0F00);
    bus.start_ex = 1'b1;
    for (int c = 1; c < 4; c++) begin
      bus.operand_ex = $urandom | 32'h8000_0000;
      tick();
    end
    bus.start_ex = 1'b0;
    tick();
    tick();
    check("hold_done_c6", 32'(bus.done), 32'd1);
    tick();
    check("hold_done_c7", 32'(bus.done), 32'd0);

    // Back-to-back: second start accepted in the done cycle.
    start_op(32'h0000_0300);
    for (int c = 1; c < 6; c++) begin
      check("b2b_busy1", 32'(bus.busy), 32'd1);
      tick();
    end
    check("b2b_done6", 32'(bus.done), 32'd1);
    start_op(32'h00F0_0000);
    for (int c = 7; c < 12; c++) begin
      check("b2b_busy2", 32'(bus.busy), 32'd1);
      check("b2b_done_early", 32'(bus.done), 32'd0);
      tick();
    end
    check("b2b_done12", 32'(bus.done), 32'd1);
    check("b2b_busy12", 32'(bus.busy), 32'd1);
    tick();
    check("b2b_busy13", 32'(bus.busy), 32'd0);

    // Flush in cycle 3, then a fresh start in cycle 4.
    start_op(32'h0000_0100);
    tick();
    tick();
    bus.flush_ex = 1'b1;
    tick();
    bus.flush_ex = 1'b0;
    void'(exp_q.pop_back());
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    start_op(32'h0400_0000);
    wait_done(10, lat);
    check("flush_restart_lat", 32'(lat), 32'd6);
    tick();

    // Reset in cycle 2.
    start_op(32'h0000_0100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_result", bus.result_ex, 32'd0);
    check("mid_rst_lz", 32'(bus.lz_cnt), 32'd0);
    check("mid_rst_zero", 32'(bus.zero), 32'd0);
    check("mid_rst_state", 32'(bus.state_dbg), 32'd0);
    repeat (8) tick();

    // Flush together with start: nothing starts.
    bus.start_ex   = 1'b1;
    bus.operand_ex = 32'h0000_00FF;
    bus.flush_ex   = 1'b1;
    tick();
    bus.start_ex = 1'b0;
    bus.flush_ex = 1'b0;
    check("fs_busy", 32'(bus.busy), 32'd0);
    check("fs_state", 32'(bus.state_dbg), 32'd0);
    repeat (8) tick();

    // Randomized operands, sometimes back-to-back from the done cycle.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 32'd0;
        1:       op = 32'd1 << $urandom_range(0, 31);
        default: op = $urandom >> $urandom_range(0, 31);
      endcase
      start_op(op);
      wait_done(10, lat);
      check("rand_lat", 32'(lat), 32'd6);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    repeat (8) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clz_normalizer.md
# clz_normalizer

Multi-cycle leading-zero counter and left-normalizer for the EX stage. Given a 32-bit operand, it finds the shift amount that brings the most-significant 1 to bit 31, and returns both that amount and the normalized value. It is the inverse of the left-shift path: it determines an amount rather than applying one. It runs beside the ALU under a start/done handshake, with flush support for pipeline squash.

## Interface
- No parameters; datapath width is fixed at 32, count width at 6.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_ex  in  1  request; sampled at a rising edge, accepted only in IDLE or DONE.
- operand_ex  in  32  value to normalize; captured on the edge that accepts start_ex.
- flush_ex  in  1  synchronous abort from hazard/branch logic.
- busy  out  1  high in SEARCH and DONE.
- done  out  1  one-cycle pulse; the result is valid in that cycle.
- result_ex  out  32  normalized value (operand << lz_cnt), or 0 for a zero operand.
- lz_cnt  out  6  leading-zero count, 0..32.
- zero  out  1  operand was 0.

## Operation
- States: IDLE, SEARCH, DONE. A 3-bit step index (4..0) selects the step width 2^k = 16, 8, 4, 2, 1.
- Start is accepted in IDLE or DONE when start_ex=1 and flush_ex=0:
  - val <= operand_ex, cnt <= 0.
  - zero_r <= (operand_ex == 0).
  - step <= 4, state <= SEARCH.
- Each SEARCH edge uses s = 2^step:
  - If val[31:32-s] == 0, then val <= val << s (zero fill) and cnt <= cnt + s.
  - step decrements. The step-0 edge moves the state to DONE.
- After 5 steps, val[31]=1 for any nonzero operand.
- DONE with no new start returns to IDLE on the next edge.
- Zero operand: the search runs normally (cnt reaches 31). On output, lz_cnt is forced to 32 and result_ex to 0, and zero=1.
- Count arithmetic: cnt is 6 bits unsigned and never exceeds 31 internally. 32 comes only from the zero override.
- start_ex while in SEARCH: ignored and not queued. The operand is not re-sampled.
- flush_ex:
  - Highest priority below rst; takes effect from any state to IDLE on the next edge.
  - done is not asserted for the aborted operation.
  - flush_ex together with start_ex: start is dropped.
- rst mid-operation: same effect as flush. All outputs return to reset values on that edge.

## Timing
- Reset values: busy=0, done=0, result_ex=0, lz_cnt=0, zero=0; state=IDLE.
- Start sampled at edge E0 (cycle 0). Edges E1..E5 perform steps 16, 8, 4, 2, 1.
- done=1 in cycle 6, so fixed latency is 6 cycles, independent of operand value.
- busy=1 in cycles 1..6 and 0 in cycle 7 unless a new start is accepted at E6.
- Back-to-back: a start asserted in the DONE cycle is accepted at E6. done then pulses in cycle 12, and busy stays high continuously. Throughput is one result per 6 cycles.
- Output stability:
  - result_ex, lz_cnt and zero are guaranteed only while done=1.
  - They hold their values afterwards until the next accepted start.
  - During SEARCH they show intermediate values; consumers must gate on done.
- done is registered (high for exactly one cycle per completed operation). No combinational path from inputs to outputs.

## Test plan
- Basic count: operand 0x0000_0001, start at cycle 0 -> done in cycle 6, lz_cnt=31, result_ex=0x8000_0000, zero=0.
- Already normalized and mixed pattern:
  - 0x8000_0000 -> lz_cnt=0, result_ex=0x8000_0000.
  - 0x0001_2345 -> lz_cnt=15, result_ex=0x91A2_8000.
- Zero operand: 0x0000_0000 -> lz_cnt=32, result_ex=0, zero=1, done in cycle 6.
- Handshake:
  - start held high in cycles 0..3 with changing operand -> only the cycle-0 operand is processed, and a single done pulse appears in cycle 6.
  - start in cycle 6 with 0x00F0_0000 -> second done in cycle 12 with lz_cnt=8, and busy never drops.
- Flush: start 0x0000_0100 at cycle 0, flush_ex in cycle 3 -> busy=0 from cycle 4, no done pulse. A new start in cycle 4 completes normally in cycle 10 with the correct result.
- Reset mid-op: rst in cycle 2 -> all outputs 0 from cycle 3, state IDLE, and no spurious done afterwards. Flush and start in the same cycle -> no operation is started.
